// File: rtl/bus_demux_3ch_if.sv
// Bus bundle for the 3-channel demux: one source port, three sink slots and the select-error flag.
// sel_err_cnt exists only when BUS_DEMUX_ERRCNT_EN is defined.
interface bus_demux_3ch_if #(
    parameter int unsigned WORD_SIZE = 8
);
    logic [WORD_SIZE-1:0] in_data;
    logic [1:0]           in_sel;
    logic                 in_valid;
    logic                 in_ready;

    logic [WORD_SIZE-1:0] out_data_a;
    logic [WORD_SIZE-1:0] out_data_b;
    logic [WORD_SIZE-1:0] out_data_c;
    logic                 out_valid_a;
    logic                 out_valid_b;
    logic                 out_valid_c;
    logic                 out_ready_a;
    logic                 out_ready_b;
    logic                 out_ready_c;

    logic                 sel_err;
`ifdef BUS_DEMUX_ERRCNT_EN
    logic [7:0]           sel_err_cnt;
`endif

    // Producer and consumers side, driven by the environment.
    modport master (
        output in_data, in_sel, in_valid, out_ready_a, out_ready_b, out_ready_c,
        input  in_ready, out_data_a, out_data_b, out_data_c,
        input  out_valid_a, out_valid_b, out_valid_c, sel_err
`ifdef BUS_DEMUX_ERRCNT_EN
        , input sel_err_cnt
`endif
    );

    // Demux side.
    modport slave (
        input  in_data, in_sel, in_valid, out_ready_a, out_ready_b, out_ready_c,
        output in_ready, out_data_a, out_data_b, out_data_c,
        output out_valid_a, out_valid_b, out_valid_c, sel_err
`ifdef BUS_DEMUX_ERRCNT_EN
        , output sel_err_cnt
`endif
    );
endinterface

// File: rtl/bus_demux_3ch.sv
// One-to-three bus demux with a one-entry slot per channel; in_sel=11 words are dropped and
// flagged on sel_err. Define BUS_DEMUX_ERRCNT_EN to add the saturating sel_err_cnt output.
module bus_demux_3ch #(
    parameter int unsigned WORD_SIZE = 8
) (
    input  logic           clk,
    input  logic           rst,
    bus_demux_3ch_if.slave bus_io
);

    localparam int unsigned NumCh = 3;

    typedef enum logic {
        StEmpty,
        StFull
    } slot_state_e;

    slot_state_e          slot_q [NumCh];
    slot_state_e          slot_d [NumCh];
    logic [WORD_SIZE-1:0] data_q [NumCh];
    logic [WORD_SIZE-1:0] data_d [NumCh];

    logic [NumCh-1:0] out_ready;
    logic [NumCh-1:0] load;
    logic             in_ready;
    logic             accept;
    logic             sel_err_q;
    logic             sel_err_d;

    assign out_ready = {bus_io.out_ready_c, bus_io.out_ready_b, bus_io.out_ready_a};

    // A full slot still accepts when its consumer drains it in the same cycle.
    always_comb begin
        in_ready = 1'b1;
        unique case (bus_io.in_sel)
            2'b00:   in_ready = (slot_q[0] == StEmpty) || out_ready[0];
            2'b01:   in_ready = (slot_q[1] == StEmpty) || out_ready[1];
            2'b10:   in_ready = (slot_q[2] == StEmpty) || out_ready[2];
            default: in_ready = 1'b1;
        endcase
    end

    assign accept = bus_io.in_valid && in_ready;

    always_comb begin
        load      = '0;
        sel_err_d = 1'b0;
        unique case (bus_io.in_sel)
            2'b00:   load[0] = accept;
            2'b01:   load[1] = accept;
            2'b10:   load[2] = accept;
            default: sel_err_d = accept;
        endcase
    end

    always_comb begin
        for (int i = 0; i < NumCh; i++) begin
            slot_d[i] = slot_q[i];
            data_d[i] = data_q[i];
            unique case (slot_q[i])
                StEmpty: if (load[i]) slot_d[i] = StFull;
                StFull:  if (out_ready[i] && !load[i]) slot_d[i] = StEmpty;
            endcase
            if (load[i]) data_d[i] = bus_io.in_data;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NumCh; i++) begin
                slot_q[i] <= StEmpty;
                data_q[i] <= '0;
            end
            sel_err_q <= 1'b0;
        end else begin
            for (int i = 0; i < NumCh; i++) begin
                slot_q[i] <= slot_d[i];
                data_q[i] <= data_d[i];
            end
            sel_err_q <= sel_err_d;
        end
    end

`ifdef BUS_DEMUX_ERRCNT_EN
    logic [7:0] err_cnt_q;
    logic [7:0] err_cnt_d;

    always_comb begin
        err_cnt_d = err_cnt_q;
        if (sel_err_d && (err_cnt_q != 8'hFF)) err_cnt_d = err_cnt_q + 8'd1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            err_cnt_q <= 8'h00;
        end else begin
            err_cnt_q <= err_cnt_d;
        end
    end

    assign bus_io.sel_err_cnt = err_cnt_q;
`endif

    assign bus_io.in_ready    = in_ready;
    assign bus_io.out_data_a  = data_q[0];
    assign bus_io.out_data_b  = data_q[1];
    assign bus_io.out_data_c  = data_q[2];
    assign bus_io.out_valid_a = (slot_q[0] == StFull);
    assign bus_io.out_valid_b = (slot_q[1] == StFull);
    assign bus_io.out_valid_c = (slot_q[2] == StFull);
    assign bus_io.sel_err     = sel_err_q;

endmodule

// File: tb/tb_bus_demux_3ch.sv
// Bench for bus_demux_3ch: directed scenarios with literal expectations plus a per-cycle
// comparison against a slot-level reference model.
module tb_bus_demux_3ch;

    logic clk;
    logic rst;
    int   n_checks = 0;
    int   n_err    = 0;

    bus_demux_3ch_if #(.WORD_SIZE(8)) bus ();

    bus_demux_3ch #(.WORD_SIZE(8)) dut (
        .clk    (clk),
        .rst    (rst),
        .bus_io (bus.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference model: each channel is a held word plus a "full" flag.
    logic       m_full [3];
    logic [7:0] m_data [3];
    logic       m_err;
    int         m_cnt;
    logic [2:0] m_rdy;

    assign m_rdy = {bus.out_ready_c, bus.out_ready_b, bus.out_ready_a};

    function automatic logic exp_ready();
        if (bus.in_sel == 2'd3) return 1'b1;
        return !m_full[bus.in_sel] || m_rdy[bus.in_sel];
    endfunction

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 3; i++) begin
                m_full[i] <= 1'b0;
                m_data[i] <= 8'h00;
            end
            m_err <= 1'b0;
            m_cnt <= 0;
        end else begin
            logic acc;
            acc = bus.in_valid && exp_ready();
            for (int i = 0; i < 3; i++) begin
                if (acc && bus.in_sel == i[1:0]) begin
                    m_full[i] <= 1'b1;
                    m_data[i] <= bus.in_data;
                end else if (m_rdy[i]) begin
                    m_full[i] <= 1'b0;
                end
            end
            m_err <= acc && (bus.in_sel == 2'd3);
            if (acc && (bus.in_sel == 2'd3) && m_cnt < 255) m_cnt <= m_cnt + 1;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, want %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (rst) begin
            chk("cyc_in_ready", {31'd0, bus.in_ready}, {31'd0, exp_ready()});
            chk("cyc_valid_a", {31'd0, bus.out_valid_a}, {31'd0, m_full[0]});
            chk("cyc_valid_b", {31'd0, bus.out_valid_b}, {31'd0, m_full[1]});
            chk("cyc_valid_c", {31'd0, bus.out_valid_c}, {31'd0, m_full[2]});
            chk("cyc_data_a", {24'd0, bus.out_data_a}, {24'd0, m_data[0]});
            chk("cyc_data_b", {24'd0, bus.out_data_b}, {24'd0, m_data[1]});
            chk("cyc_data_c", {24'd0, bus.out_data_c}, {24'd0, m_data[2]});
            chk("cyc_sel_err", {31'd0, bus.sel_err}, {31'd0, m_err});
`ifdef BUS_DEMUX_ERRCNT_EN
            chk("cyc_err_cnt", {24'd0, bus.sel_err_cnt}, m_cnt);
`endif
        end
    end

    task automatic offer(input logic v, input logic [1:0] s, input logic [7:0] d);
        bus.in_valid = v;
        bus.in_sel   = s;
        bus.in_data  = d;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [7:0] stream [3];

    initial begin
        stream[0] = 8'h34;
        stream[1] = 8'h56;
        stream[2] = 8'h78;
        rst = 1'b1;
        offer(1'b0, 2'd0, 8'h00);
        bus.out_ready_a = 1'b0;
        bus.out_ready_b = 1'b0;
        bus.out_ready_c = 1'b0;
        #1 rst = 1'b0;
        #2;
        chk("rst_valid_a", {31'd0, bus.out_valid_a}, 32'd0);
        chk("rst_data_b", {24'd0, bus.out_data_b}, 32'd0);
        chk("rst_sel_err", {31'd0, bus.sel_err}, 32'd0);
        tick();
        tick();
        rst = 1'b1;

        // Routing
        offer(1'b1, 2'd0, 8'hAA);
        tick();
        offer(1'b1, 2'd1, 8'hBB);
        tick();
        offer(1'b1, 2'd2, 8'hCC);
        tick();
        offer(1'b0, 2'd0, 8'h00);
        chk("route_data_a", {24'd0, bus.out_data_a}, 32'hAA);
        chk("route_data_b", {24'd0, bus.out_data_b}, 32'hBB);
        chk("route_data_c", {24'd0, bus.out_data_c}, 32'hCC);
        chk("route_valids", {29'd0, bus.out_valid_c, bus.out_valid_b, bus.out_valid_a}, 32'd7);
        for (int s = 0; s < 3; s++) begin
            bus.in_sel = s[1:0];
            #1 chk("route_in_ready", {31'd0, bus.in_ready}, 32'd0);
        end

        // Backpressure on channel a
        offer(1'b1, 2'd0, 8'h12);
        for (int k = 0; k < 3; k++) begin
            #1 chk("bp_in_ready", {31'd0, bus.in_ready}, 32'd0);
            tick();
            chk("bp_hold_a", {24'd0, bus.out_data_a}, 32'hAA);
        end
        bus.out_ready_a = 1'b1;
        #1 chk("bp_in_ready_rel", {31'd0, bus.in_ready}, 32'd1);
        tick();
        offer(1'b0, 2'd0, 8'h00);
        bus.out_ready_a = 1'b0;
        chk("bp_data_a", {24'd0, bus.out_data_a}, 32'h12);
        chk("bp_valid_a", {31'd0, bus.out_valid_a}, 32'd1);

        // Streaming through channel b
        bus.out_ready_b = 1'b1;
        for (int k = 0; k < 3; k++) begin
            offer(1'b1, 2'd1, stream[k]);
            #1 chk("st_in_ready", {31'd0, bus.in_ready}, 32'd1);
            tick();
            chk("st_data_b", {24'd0, bus.out_data_b}, {24'd0, stream[k]});
        end
        offer(1'b0, 2'd1, 8'h00);
        tick();
        chk("st_drained_b", {31'd0, bus.out_valid_b}, 32'd0);
        chk("st_keep_b", {24'd0, bus.out_data_b}, 32'h78);
        bus.out_ready_b = 1'b0;

        // Invalid select
        offer(1'b1, 2'd3, 8'h99);
        #1 chk("inv_in_ready", {31'd0, bus.in_ready}, 32'd1);
        tick();
        offer(1'b0, 2'd3, 8'hxx);
        chk("inv_sel_err", {31'd0, bus.sel_err}, 32'd1);
        chk("inv_valids", {29'd0, bus.out_valid_c, bus.out_valid_b, bus.out_valid_a}, 32'd5);
        tick();
        chk("inv_sel_err_end", {31'd0, bus.sel_err}, 32'd0);
        tick();
        chk("idle_sel_err", {31'd0, bus.sel_err}, 32'd0);

`ifdef BUS_DEMUX_ERRCNT_EN
        offer(1'b1, 2'd3, 8'h00);
        repeat (300) tick();
        offer(1'b0, 2'd0, 8'h00);
        tick();
        chk("cnt_saturate", {24'd0, bus.sel_err_cnt}, 32'hFF);
`endif

        // Asynchronous reset mid-stream with every slot full and sel_err high
        offer(1'b1, 2'd1, 8'h77);
        tick();
        offer(1'b1, 2'd3, 8'h66);
        tick();
        offer(1'b1, 2'd0, 8'h44);
        chk("pre_rst_valids", {29'd0, bus.out_valid_c, bus.out_valid_b, bus.out_valid_a}, 32'd7);
        chk("pre_rst_sel_err", {31'd0, bus.sel_err}, 32'd1);
        #2 rst = 1'b0;
        #1;
        chk("arst_valids", {29'd0, bus.out_valid_c, bus.out_valid_b, bus.out_valid_a}, 32'd0);
        chk("arst_data", {8'd0, bus.out_data_a, bus.out_data_b, bus.out_data_c}, 32'd0);
        chk("arst_sel_err", {31'd0, bus.sel_err}, 32'd0);
`ifdef BUS_DEMUX_ERRCNT_EN
        chk("arst_cnt", {24'd0, bus.sel_err_cnt}, 32'd0);
`endif
        #2;
        rst = 1'b1;
        offer(1'b1, 2'd0, 8'h5A);
        tick();
        offer(1'b0, 2'd0, 8'h00);
        chk("first_acc_data_a", {24'd0, bus.out_data_a}, 32'h5A);
        chk("first_acc_valid_a", {31'd0, bus.out_valid_a}, 32'd1);
        tick();
        tick();

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
